// File: rtl/pc_ras.sv
// pc_ras: program counter with a return-address stack for call/return.
// Define PC_RAS_WRAP_EN to make the RAS circular (a call when full overwrites the oldest entry).
module pc_ras #(
    parameter int D     = 12,
    parameter int T     = 8,
    parameter int DEPTH = 4,
    parameter int SKIP  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       branch_en,
    input  logic                       zero,
    input  logic                       jump_en,
    input  logic                       call_en,
    input  logic                       ret_en,
    input  logic                       rel_en,
    input  logic [T-1:0]               target,
    output logic [D-1:0]               prog_ctr,
    output logic [D-1:0]               ret_top,
    output logic [$clog2(DEPTH+1)-1:0] ras_depth,
    output logic                       ras_overflow,
    output logic                       ras_underflow
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [D-1:0]  pc_q, pc_d;
    logic [DW-1:0] depth_q, depth_d;
    logic [D-1:0]  stack_q [DEPTH];
    logic [D-1:0]  stack_d [DEPTH];
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic [D-1:0]  pc_inc;
    logic [D-1:0]  pc_skip;
    logic [D-1:0]  tgt_sext;
    logic [D-1:0]  tgt_abs;
    logic [D-1:0]  jmp_addr;
    logic [D-1:0]  top_val;
    logic [IW-1:0] top_idx;
    logic [IW-1:0] push_idx;
    logic          ras_empty;
    logic          ras_full;

    // Entries live at indices 0..depth-1; the newest is at depth-1.
    if (T == D) begin : g_full_tgt
        assign tgt_sext = target;
        assign tgt_abs  = target;
    end else begin : g_part_tgt
        assign tgt_sext = {{(D-T){target[T-1]}}, target};
        assign tgt_abs  = {pc_q[D-1:T], target};
    end

    assign pc_inc    = pc_q + D'(1);
    assign pc_skip   = pc_q + D'(SKIP);
    assign jmp_addr  = rel_en ? (pc_q + tgt_sext) : tgt_abs;

    assign ras_empty = (depth_q == '0);
    assign ras_full  = (depth_q == DW'(DEPTH));
    assign top_idx   = IW'(depth_q - DW'(1));
    assign push_idx  = IW'(depth_q);
    assign top_val   = ras_empty ? '0 : stack_q[top_idx];

    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        stack_d = stack_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (!stall) begin
            if (ret_en) begin
                if (!ras_empty) begin
                    pc_d    = top_val;
                    depth_d = depth_q - DW'(1);
                end else begin
                    pc_d  = pc_inc;
                    unf_d = 1'b1;
                end
            end else if (call_en) begin
                pc_d = jmp_addr;
                if (!ras_full) begin
                    stack_d[push_idx] = pc_inc;
                    depth_d           = depth_q + DW'(1);
                end else begin
                    ovf_d = 1'b1;
`ifdef PC_RAS_WRAP_EN
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        stack_d[i] = stack_q[i+1];
                    end
                    stack_d[DEPTH-1] = pc_inc;
`endif
                end
            end else if (jump_en) begin
                pc_d = jmp_addr;
            end else if (branch_en && zero) begin
                pc_d = pc_skip;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

    assign prog_ctr      = pc_q;
    assign ret_top       = top_val;
    assign ras_depth     = depth_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: doc/pc_ras.md
Name: pc_ras

Overview:
- Program counter with a return-address stack (RAS) for call/return.
- Generalises the current counter in four ways: parametrised widths, relative or absolute jump addressing, a configurable branch skip distance, and a stall input.
- Feeds instruction memory address; sits between the control decoder (enables) and instruction ROM.
- Adds sticky overflow/underflow flags for RAS misuse.

Parameters:
- D, 12, program-counter width in bits.
- T, 8, target field width; requires T <= D.
- DEPTH, 4, RAS entries; requires DEPTH >= 1.
- SKIP, 2, increment applied on a taken branch.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold all state this cycle.
- branch_en  input  1  conditional skip request.
- zero  input  1  branch condition from ALU.
- jump_en  input  1  unconditional jump.
- call_en  input  1  jump and push return address.
- ret_en  input  1  pop return address into PC.
- rel_en  input  1  1 = relative addressing for jump/call; 0 = absolute.
- target  input  T  jump/call target or signed offset.
- prog_ctr  output  D  current PC.
- ret_top  output  D  top RAS entry; 0 when RAS empty.
- ras_depth  output  $clog2(DEPTH+1)  entries in use.
- ras_overflow  output  1  sticky: call attempted while full.
- ras_underflow  output  1  sticky: return attempted while empty.

Behaviour:
- Reset (asynchronous, active-high):
  - prog_ctr=0, ras_depth=0, all RAS entries=0, both flags=0.
  - Takes effect immediately, including mid-stall.
  - The first update after release is the first rising edge with reset low.
- Update rules, one per rising edge, priority highest first:
  - stall=1: all state holds; enables ignored; flags unchanged.
  - ret_en, RAS not empty: prog_ctr <= RAS[top]; ras_depth-1.
  - ret_en, RAS empty: prog_ctr <= prog_ctr+1; ras_underflow <= 1.
  - call_en, RAS not full: push prog_ctr+1; ras_depth+1; prog_ctr <= jump address.
  - call_en, RAS full: prog_ctr <= jump address; ras_overflow <= 1; push behaviour per Optional Feature.
  - jump_en: prog_ctr <= jump address.
  - branch_en && zero: prog_ctr <= prog_ctr+SKIP.
  - Otherwise (including branch_en with zero=0): prog_ctr <= prog_ctr+1.
- Jump address:
  - rel_en=1: prog_ctr + sign-extend(target) to D bits.
  - rel_en=0: {prog_ctr[D-1:T], target}; if T==D, target alone.
- Arithmetic:
  - All PC arithmetic is modulo 2^D, so wrap-around is silent: 0xFFF+1 gives 0x000 for D=12.
  - A pushed return address also wraps.
- Simultaneous enables: lower-priority enables are ignored entirely, with no side effects; e.g. call_en+jump_en acts as a call.
- Flags: sticky; cleared only by reset.
- ret_top and ras_depth: driven combinationally from registered state only, never from inputs.
- Latency: one cycle from enables to prog_ctr.

Optional Feature:
- Macro: PC_RAS_WRAP_EN.
- Defined: RAS is circular; a call when full overwrites the oldest entry; ras_depth stays DEPTH; ras_overflow is still set.
- Not defined: a call when full drops the push; RAS contents and ras_depth are unchanged; the jump is still taken.

Test Plan:
- Reset then 3 idle edges -> prog_ctr 0,1,2,3; assert reset asynchronously mid-cycle -> prog_ctr=0 before next edge.
- prog_ctr=0x010, branch_en=1 zero=1 -> 0x012; branch_en=1 zero=0 -> 0x013.
- prog_ctr=0x345, jump_en=1 rel_en=0 target=0x7A -> 0x37A; rel_en=1 target=0xFE -> 0x378; prog_ctr=0xFFF with idle edge -> 0x000.
- At 0x020, call target=0x40 abs -> PC 0x040, ret_top 0x021, depth 1; then ret_en -> PC 0x021, depth 0, ret_top 0.
- Five calls with DEPTH=4 -> ras_overflow=1, depth 4; four rets return the newest four addresses (macro defined) or the first four (macro undefined); a fifth ret -> ras_underflow=1, PC+1.
- stall=1 with call_en=1 -> no change to PC/RAS/flags; call_en+ret_en together -> return only.
